// File: rtl/combat_pkg.sv
// -----------------------------------------------------------------------------
// combat_pkg
// Shared definitions for the two-player combat controller: attack and round
// state encodings, USB HID keycodes, hitbox sizes, counter widths and the
// small helpers used for key decoding and reach/hitbox overlap.
// -----------------------------------------------------------------------------
package combat_pkg;

  // Attack phase encoding; the numeric values are visible on the AtkState ports.
  typedef enum logic [1:0] {
    ATK_IDLE    = 2'd0,
    ATK_WINDUP  = 2'd1,
    ATK_ACTIVE  = 2'd2,
    ATK_RECOVER = 2'd3
  } atk_state_e;

  typedef enum logic [1:0] {
    RND_FIGHT = 2'd0,
    RND_KO    = 2'd1,
    RND_DONE  = 2'd2
  } round_state_e;

  // USB HID usage IDs for the bound keys.
  localparam logic [7:0] KEY_P1_ATK  = 8'h08;  // E
  localparam logic [7:0] KEY_P1_BLK  = 8'h16;  // S
  localparam logic [7:0] KEY_P2_ATK  = 8'h12;  // O
  localparam logic [7:0] KEY_P2_BLK  = 8'h0E;  // K
  localparam logic [7:0] KEY_RESTART = 8'h28;  // Enter

  // Hitbox sizes, already widened to the 11-bit overlap arithmetic width.
  localparam logic [10:0] P1_W = 11'd120;
  localparam logic [10:0] P1_H = 11'd180;
  localparam logic [10:0] P2_W = 11'd140;
  localparam logic [10:0] P2_H = 11'd240;

  localparam int PHASE_W = 8;   // attack-phase and flash counters
  localparam int KO_W    = 16;  // KO hold counter

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // A key counts as held when any of the four report slots carries its code.
  function automatic logic key_held(input logic [7:0] k0, input logic [7:0] k1,
                                    input logic [7:0] k2, input logic [7:0] k3,
                                    input logic [7:0] code);
    return (k0 == code) || (k1 == code) || (k2 == code) || (k3 == code);
  endfunction

  // Attacker reach box against defender hitbox, inclusive edges. The reach box
  // sits on the side facing the defender and is clamped at x = 0 on the left.
  function automatic logic reach_overlap(input logic [10:0] ax, input logic [10:0] ay,
                                         input logic [10:0] aw, input logic [10:0] ah,
                                         input logic [10:0] dx, input logic [10:0] dy,
                                         input logic [10:0] dw, input logic [10:0] dh,
                                         input logic [10:0] reach);
    logic [10:0] lo;
    logic [10:0] hi;
    if (ax < dx) begin
      lo = ax + aw;
      hi = ax + aw + reach;
    end else begin
      lo = (ax > reach) ? ax - reach : 11'd0;
      hi = ax;
    end
    return (lo <= dx + dw) && (dx <= hi) && (ay <= dy + dh) && (dy <= ay + ah);
  endfunction

endpackage

// File: rtl/attack_fsm.sv
// -----------------------------------------------------------------------------
// attack_fsm
// One player's attack sequencer: rising-edge detector on the attack key,
// IDLE -> WINDUP -> ACTIVE -> RECOVER -> IDLE phase machine with its frame
// counter, and the flag that limits each attack to a single hit.
//
// Ports
//   frame_clk     in   frame-rate clock
//   Reset         in   asynchronous, active-high reset
//   atk_held      in   attack key held this frame
//   allow_start   in   round currently in FIGHT, new attacks may begin
//   force_idle    in   round leaving/outside FIGHT, abort any attack now
//   hit           in   this attack connects on the current frame
//   atk_state     out  current phase (0 idle, 1 windup, 2 active, 3 recover)
//   hit_consumed  out  this attack has already landed its hit
// -----------------------------------------------------------------------------
module attack_fsm
  import combat_pkg::*;
#(
  parameter int unsigned WINDUP  = 4,
  parameter int unsigned ACTIVE  = 3,
  parameter int unsigned RECOVER = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       atk_held,
  input  logic       allow_start,
  input  logic       force_idle,
  input  logic       hit,
  output logic [1:0] atk_state,
  output logic       hit_consumed
);

  atk_state_e         state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic               consumed_q, consumed_d;
  logic               held_prev_q, held_prev_d;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    consumed_d  = consumed_q | hit;
    held_prev_d = atk_held;

    if (force_idle) begin
      state_d    = ATK_IDLE;
      cnt_d      = '0;
      consumed_d = 1'b0;
    end else begin
      case (state_q)
        ATK_IDLE: begin
          // Only a fresh press starts an attack; holding the key does nothing.
          if (allow_start && atk_held && !held_prev_q) begin
            state_d    = ATK_WINDUP;
            cnt_d      = '0;
            consumed_d = 1'b0;
          end
        end
        ATK_WINDUP: begin
          if (cnt_q == PHASE_W'(WINDUP - 1)) begin
            state_d = ATK_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PHASE_W'(1);
          end
        end
        ATK_ACTIVE: begin
          if (cnt_q == PHASE_W'(ACTIVE - 1)) begin
            state_d = ATK_RECOVER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PHASE_W'(1);
          end
        end
        ATK_RECOVER: begin
          if (cnt_q == PHASE_W'(RECOVER - 1)) begin
            state_d = ATK_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PHASE_W'(1);
          end
        end
        default: begin
          state_d = ATK_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments belong in always_comb only.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ATK_IDLE;
      cnt_q       <= '0;
      consumed_q  <= 1'b0;
      held_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      consumed_q  <= consumed_d;
      held_prev_q <= held_prev_d;
    end
  end

  assign atk_state    = state_q;
  assign hit_consumed = consumed_q;

endmodule

// File: rtl/combat_ctrl.sv
// -----------------------------------------------------------------------------
// combat_ctrl
// Two-player combat controller advanced once per video frame. Decodes the
// held keys, runs one attack_fsm per player, resolves hits (reach box versus
// opponent hitbox, blocked or not), keeps health and hit-flash timers and runs
// the round FIGHT -> KO -> DONE -> FIGHT sequence.
//
// Ports
//   frame_clk                in   frame-rate clock
//   Reset                    in   asynchronous, active-high reset
//   keycode_0..keycode_3     in   currently held HID keycodes, 0x00 = none
//   Player1X/Y, Player2X/Y   in   sprite top-left positions in pixels
//   P1_Health, P2_Health     out  remaining health
//   P1_AtkState, P2_AtkState out  attack phase (0 idle,1 windup,2 active,3 recover)
//   P1_Flash, P2_Flash       out  player inside its hit-flash window
//   Round_Over               out  round in KO or DONE
//   Winner                   out  0 none, 1 P1, 2 P2, 3 draw
// -----------------------------------------------------------------------------
module combat_ctrl
  import combat_pkg::*;
#(
  parameter int unsigned MAX_HEALTH = 100,
  parameter int unsigned HIT_DMG    = 10,
  parameter int unsigned BLOCK_DMG  = 2,
  parameter int unsigned REACH      = 30,
  parameter int unsigned WINDUP     = 4,
  parameter int unsigned ACTIVE     = 3,
  parameter int unsigned RECOVER    = 8,
  parameter int unsigned KO_HOLD    = 120,
  parameter int unsigned FLASH_LEN  = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  input  logic [9:0] Player1X,
  input  logic [9:0] Player1Y,
  input  logic [9:0] Player2X,
  input  logic [9:0] Player2Y,
  output logic [6:0] P1_Health,
  output logic [6:0] P2_Health,
  output logic [1:0] P1_AtkState,
  output logic [1:0] P2_AtkState,
  output logic       P1_Flash,
  output logic       P2_Flash,
  output logic       Round_Over,
  output logic [1:0] Winner
);

  localparam logic [6:0]         HEALTH_FULL = 7'(MAX_HEALTH);
  localparam logic [6:0]         DMG_HIT     = 7'(HIT_DMG);
  localparam logic [6:0]         DMG_BLOCK   = 7'(BLOCK_DMG);
  localparam logic [10:0]        REACH_PX    = 11'(REACH);
  localparam logic [PHASE_W-1:0] FLASH_INIT  = PHASE_W'(FLASH_LEN);
  localparam logic [KO_W-1:0]    KO_LAST     = KO_W'(KO_HOLD - 1);

  function automatic logic [6:0] apply_dmg(input logic [6:0] health, input logic [6:0] dmg);
    return (health > dmg) ? health - dmg : 7'd0;
  endfunction

  // Key decode
  logic p1_atk_key, p1_blk_key, p2_atk_key, p2_blk_key, restart_key;
  assign p1_atk_key  = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_ATK);
  assign p1_blk_key  = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_BLK);
  assign p2_atk_key  = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_ATK);
  assign p2_blk_key  = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_BLK);
  assign restart_key = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_RESTART);

  // Positions widened so right-edge-plus-reach sums cannot wrap.
  logic [10:0] p1_x, p1_y, p2_x, p2_y;
  assign p1_x = {1'b0, Player1X};
  assign p1_y = {1'b0, Player1Y};
  assign p2_x = {1'b0, Player2X};
  assign p2_y = {1'b0, Player2Y};

  round_state_e       round_q, round_d;
  logic [6:0]         p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [PHASE_W-1:0] p1_flash_q, p1_flash_d, p2_flash_q, p2_flash_d;
  logic [KO_W-1:0]    ko_cnt_q, ko_cnt_d;
  logic [1:0]         winner_q, winner_d;

  logic [1:0] p1_atk_state, p2_atk_state;
  logic       p1_consumed, p2_consumed;
  logic       p1_hit, p2_hit;
  logic       fight, force_idle;

  assign fight = (round_q == RND_FIGHT);
  // Attacks are aborted on the same edge the round leaves FIGHT, so the first
  // KO frame already shows both players idle.
  assign force_idle = (round_d != RND_FIGHT);

  attack_fsm #(
    .WINDUP (WINDUP),
    .ACTIVE (ACTIVE),
    .RECOVER(RECOVER)
  ) u_p1_atk (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .atk_held    (p1_atk_key),
    .allow_start (fight),
    .force_idle  (force_idle),
    .hit         (p1_hit),
    .atk_state   (p1_atk_state),
    .hit_consumed(p1_consumed)
  );

  attack_fsm #(
    .WINDUP (WINDUP),
    .ACTIVE (ACTIVE),
    .RECOVER(RECOVER)
  ) u_p2_atk (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .atk_held    (p2_atk_key),
    .allow_start (fight),
    .force_idle  (force_idle),
    .hit         (p2_hit),
    .atk_state   (p2_atk_state),
    .hit_consumed(p2_consumed)
  );

  // Hits are decided from registered attack state only, so hit -> health is a
  // clean one-frame registered path with no loop through the attack FSMs.
  assign p1_hit = fight && (p1_atk_state == ATK_ACTIVE) && !p1_consumed &&
                  reach_overlap(p1_x, p1_y, P1_W, P1_H, p2_x, p2_y, P2_W, P2_H, REACH_PX);
  assign p2_hit = fight && (p2_atk_state == ATK_ACTIVE) && !p2_consumed &&
                  reach_overlap(p2_x, p2_y, P2_W, P2_H, p1_x, p1_y, P1_W, P1_H, REACH_PX);

  always_comb begin
    round_d     = round_q;
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    ko_cnt_d    = ko_cnt_q;
    winner_d    = winner_q;
    p1_flash_d  = (p1_flash_q != '0) ? p1_flash_q - PHASE_W'(1) : '0;
    p2_flash_d  = (p2_flash_q != '0) ? p2_flash_q - PHASE_W'(1) : '0;

    case (round_q)
      RND_FIGHT: begin
        // Both hits are applied independently, so a trade lands on both players.
        if (p2_hit) begin
          p1_health_d = apply_dmg(p1_health_q, p1_blk_key ? DMG_BLOCK : DMG_HIT);
          p1_flash_d  = FLASH_INIT;
        end
        if (p1_hit) begin
          p2_health_d = apply_dmg(p2_health_q, p2_blk_key ? DMG_BLOCK : DMG_HIT);
          p2_flash_d  = FLASH_INIT;
        end
        if ((p1_health_d == 7'd0) || (p2_health_d == 7'd0)) begin
          round_d  = RND_KO;
          ko_cnt_d = '0;
          if ((p1_health_d == 7'd0) && (p2_health_d == 7'd0)) winner_d = WIN_DRAW;
          else if (p2_health_d == 7'd0)                        winner_d = WIN_P1;
          else                                                 winner_d = WIN_P2;
        end
      end
      RND_KO: begin
        if (ko_cnt_q == KO_LAST) begin
          round_d = RND_DONE;
        end else begin
          ko_cnt_d = ko_cnt_q + KO_W'(1);
        end
      end
      RND_DONE: begin
        if (restart_key) begin
          round_d     = RND_FIGHT;
          p1_health_d = HEALTH_FULL;
          p2_health_d = HEALTH_FULL;
          winner_d    = WIN_NONE;
          p1_flash_d  = '0;
          p2_flash_d  = '0;
          ko_cnt_d    = '0;
        end
      end
      default: round_d = RND_FIGHT;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      round_q     <= RND_FIGHT;
      p1_health_q <= HEALTH_FULL;
      p2_health_q <= HEALTH_FULL;
      p1_flash_q  <= '0;
      p2_flash_q  <= '0;
      ko_cnt_q    <= '0;
      winner_q    <= WIN_NONE;
    end else begin
      round_q     <= round_d;
      p1_health_q <= p1_health_d;
      p2_health_q <= p2_health_d;
      p1_flash_q  <= p1_flash_d;
      p2_flash_q  <= p2_flash_d;
      ko_cnt_q    <= ko_cnt_d;
      winner_q    <= winner_d;
    end
  end

  assign P1_Health   = p1_health_q;
  assign P2_Health   = p2_health_q;
  assign P1_AtkState = p1_atk_state;
  assign P2_AtkState = p2_atk_state;
  assign P1_Flash    = (p1_flash_q != '0);
  assign P2_Flash    = (p2_flash_q != '0);
  assign Round_Over  = (round_q != RND_FIGHT);
  assign Winner      = winner_q;

endmodule
